mdriver_arbiter: RTL and testbench

Round-robin arbiter that shares one memory-driver master port (the exec/we/address/data/fin handshake consumed by the AXI-lite master wrapper) between NREQ requesters, e.g. SimpRisc instruction fetch and load/store.
- Serialises requests so that at most one transaction is in flight downstream.
- Returns read data and a completion pulse to the owning requester.
- Supports a lock for back-to-back atomic sequences (read-modify-write), with an idle-timeout release.

---
 rtl/mdriver_pkg.sv | 14 +
 rtl/mdriver_arbiter_rr_pick.sv | 43 ++++
 rtl/mdriver_arbiter.sv | 127 ++++++++++++
 tb/tb_mdriver_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdriver_pkg.sv
// Shared types and default widths for the memory-driver arbiter slice.
package mdriver_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

endpackage

// File: rtl/mdriver_arbiter_rr_pick.sv
// Combinational round-robin picker. The search starts one past the last grant.
// With the lock held, only the current owner may win.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  input  logic            lock_r,
  input  logic [IW-1:0]   owner,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  always_comb begin
    logic          found;
    int            cand;
    logic [IW-1:0] cand_idx;
    // NOTE: every output and local gets a default before any branch, so no path leaves a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    if (lock_r) begin
      if (req[owner]) begin
        grant[owner] = 1'b1;
        grant_idx    = owner;
      end
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        cand     = (int'(last_grant) + k) % NREQ;
        cand_idx = IW'(cand);
        if (!found && req[cand_idx]) begin
          found           = 1'b1;
          grant[cand_idx] = 1'b1;
          grant_idx       = cand_idx;
        end
      end
    end
  end

endmodule

// File: rtl/mdriver_arbiter.sv
// Shares one memory-driver master port between NREQ requesters.
// Arbitration is round-robin, one transaction is in flight at a time, and an optional lock lets the owner keep the port.
module mdriver_arbiter
  import mdriver_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ-1:0]         req_lock,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*DW-1:0]      req_wdata,
  output logic [NREQ-1:0]         rsp_done,
  output logic [DW-1:0]           rsp_rdata,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    m_exec,
  output logic                    m_we,
  output logic [AW-1:0]           m_addr,
  output logic [DW-1:0]           m_wdata,
  input  logic [DW-1:0]           m_rdata,
  input  logic                    m_fin
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW:0] LOCK_LIMIT = (CW + 1)'(LOCK_TIMEOUT);

  arb_state_t    state;
  logic [IW-1:0] last_grant;
  logic          lock_r;
  logic [CW-1:0] lock_cnt;

  logic [AW-1:0] addr_arr  [NREQ];
  logic [DW-1:0] wdata_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*AW +: AW];
    assign wdata_arr[i] = req_wdata[i*DW +: DW];
  end

  // The lock expires in the very IDLE cycle that the silent count reaches the limit.
  logic [CW:0] cnt_inc;
  logic        lock_expire;
  logic        lock_eff;

  assign cnt_inc     = {1'b0, lock_cnt} + (CW + 1)'(1);
  assign lock_expire = lock_r && !req_valid[grant_id] && (cnt_inc >= LOCK_LIMIT);
  assign lock_eff    = lock_r && !lock_expire;

  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .lock_r     (lock_eff),
    .owner      (grant_id),
    .grant      (pick_grant),
    .grant_idx  (pick_idx)
  );

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      m_exec     <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      rsp_done   <= '0;
      rsp_rdata  <= '0;
      grant_id   <= '0;
      last_grant <= IW'(NREQ - 1);
      lock_r     <= 1'b0;
      lock_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pick_grant) begin
            state      <= ISSUE;
            m_exec     <= 1'b1;
            m_we       <= req_we[pick_idx];
            m_addr     <= addr_arr[pick_idx];
            m_wdata    <= wdata_arr[pick_idx];
            grant_id   <= pick_idx;
            last_grant <= pick_idx;
            lock_r     <= req_lock[pick_idx];
            lock_cnt   <= '0;
          end else if (lock_expire) begin
            lock_r   <= 1'b0;
            lock_cnt <= '0;
          end else if (lock_r) begin
            lock_cnt <= cnt_inc[CW-1:0];
          end
        end
        ISSUE: begin
          m_exec <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (m_fin) begin
            rsp_rdata          <= m_rdata;
            rsp_done[grant_id] <= 1'b1;
            state              <= DONE;
          end
        end
        DONE: begin
          rsp_done <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdriver_arbiter.sv
// Self-checking bench for mdriver_arbiter. It combines a driver model, a response scoreboard,
// a table of arbitration rounds, and hand-written lock, timeout and reset sequences.
module tb_mdriver_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req_valid, req_we, req_lock;
  logic [63:0]     req_addr, req_wdata;
  logic [NREQ-1:0] rsp_done;
  logic [DW-1:0]   rsp_rdata;
  logic [0:0]      grant_id;
  logic            busy, m_exec, m_we, m_fin;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata, m_rdata;

  mdriver_arbiter #(
    .NREQ         (NREQ),
    .AW           (AW),
    .DW           (DW),
    .LOCK_TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_done  (rsp_done),
    .rsp_rdata (rsp_rdata),
    .grant_id  (grant_id),
    .busy      (busy),
    .m_exec    (m_exec),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_fin     (m_fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    int          fin_dly;
    int          exp_id;
  } vec_t;
  vec_t vecs [8];

  int fin_dly   = 2;
  int drv_cnt   = 0;
  int last_exec = -1;
  bit drv_abort = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic set_req(input int r, input logic v, input logic we, input logic lk,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[r]          = v;
    req_we[r]             = we;
    req_lock[r]           = lk;
    req_addr[r*32 +: 32]  = a;
    req_wdata[r*32 +: 32] = d;
  endtask

  task automatic push_exp(input int id, input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.id = id; e.we = we; e.addr = a; e.wdata = d;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_m_exec"}, m_exec, 0);
    check({tag, "_m_we"}, m_we, 0);
    check({tag, "_m_addr"}, m_addr, 0);
    check({tag, "_m_wdata"}, m_wdata, 0);
    check({tag, "_rsp_done"}, rsp_done, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Returns at the negedge of the DONE cycle (rsp_done visible), or after a bounded wait.
  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (rsp_done == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (rsp_done == '0) begin
      total++;
      bad++;
      $display("FAIL wait_done: no rsp_done within 60 cycles (cycle %0d)", cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Driver model: m_fin comes fin_dly cycles after m_exec. Master outputs are checked against the expected transaction.
  initial begin
    m_fin   = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      m_fin = 1'b0;
      if (drv_cnt > 0) begin
        if (!drv_abort) begin
          if (sb_q.size() == 0) check("drv_hold_no_exp", 1, 0);
          else begin
            check("drv_hold_we", m_we, sb_q[0].we);
            check("drv_hold_addr", m_addr, sb_q[0].addr);
            check("drv_hold_wdata", m_wdata, sb_q[0].wdata);
            check("drv_hold_exec_low", m_exec, 0);
          end
        end
        drv_cnt--;
        if (drv_cnt == 0) begin
          m_fin   = 1'b1;
          m_rdata = rd_model(m_addr);
        end
      end
      if (m_exec && !drv_abort) begin
        if (last_exec >= 0) check("exec_spacing_ge4", (cyc - last_exec) >= 4, 1);
        last_exec = cyc;
        if (sb_q.size() == 0) check("exec_no_exp", 1, 0);
        else begin
          check("exec_we", m_we, sb_q[0].we);
          check("exec_addr", m_addr, sb_q[0].addr);
          check("exec_wdata", m_wdata, sb_q[0].wdata);
        end
        drv_cnt = fin_dly;
      end
    end
  end

  // Scoreboard: every completion pulse is matched to the oldest expected transaction.
  initial forever begin
    exp_t       e;
    logic [1:0] oh;
    @(negedge clk);
    if (rsp_done !== '0) begin
      if (sb_q.size() == 0) check("stray_rsp_done", rsp_done, 0);
      else begin
        e  = sb_q.pop_front();
        oh = 2'b01 << e.id;
        check("sb_rsp_done", rsp_done, oh);
        check("sb_grant_id", grant_id, e.id);
        if (!e.we) check("sb_rdata", rsp_rdata, rd_model(e.addr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    reset = 1'b1;

    vecs[0] = '{2'b11, 2'b00, 32'h100, 32'h104, 32'h0, 32'h0, 2, 0};
    vecs[1] = '{2'b11, 2'b00, 32'h108, 32'h104, 32'h0, 32'h0, 3, 1};
    vecs[2] = '{2'b11, 2'b00, 32'h108, 32'h10C, 32'h0, 32'h0, 2, 0};
    vecs[3] = '{2'b11, 2'b00, 32'h110, 32'h10C, 32'h0, 32'h0, 4, 1};
    vecs[4] = '{2'b01, 2'b00, 32'h110, 32'h0, 32'h0, 32'h0, 2, 0};
    vecs[5] = '{2'b10, 2'b10, 32'h0, 32'h20, 32'h0, 32'h1234, 2, 1};
    vecs[6] = '{2'b01, 2'b01, 32'h30, 32'h0, 32'hCAFEF00D, 32'h0, 5, 0};
    vecs[7] = '{2'b10, 2'b00, 32'h0, 32'h3C, 32'h0, 32'h0, 3, 1};

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;

    // Single read with cycle-exact latency.
    set_req(0, 1, 0, 0, 32'h10, 32'h0);
    fin_dly = 2;
    push_exp(0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("rd_c1_exec", m_exec, 1);
    check("rd_c1_addr", m_addr, 32'h10);
    check("rd_c1_busy", busy, 1);
    @(negedge clk);
    check("rd_c2_exec", m_exec, 0);
    check("rd_c2_addr", m_addr, 32'h10);
    @(negedge clk);
    check("rd_c3_addr", m_addr, 32'h10);
    check("rd_c3_no_done", rsp_done, 0);
    @(negedge clk);
    check("rd_c4_done", rsp_done, 2'b01);
    check("rd_c4_rdata", rsp_rdata, 32'hDEADBEEF);
    set_req(0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("rd_c5_idle", busy, 0);
    check("rd_c5_done_low", rsp_done, 0);

    // Arbitration rounds from reset: grants alternate, starting with requester 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_req(0, vecs[i].valid[0], vecs[i].we[0], 0, vecs[i].addr0, vecs[i].wdata0);
      set_req(1, vecs[i].valid[1], vecs[i].we[1], 0, vecs[i].addr1, vecs[i].wdata1);
      fin_dly = vecs[i].fin_dly;
      if (vecs[i].exp_id == 0) push_exp(0, vecs[i].we[0], vecs[i].addr0, vecs[i].wdata0);
      else                     push_exp(1, vecs[i].we[1], vecs[i].addr1, vecs[i].wdata1);
      wait_done();
    end
    set_req(0, 0, 0, 0, 32'h0, 32'h0);
    set_req(1, 0, 0, 0, 32'h0, 32'h0);

    // Lock: requester 0 keeps the port across three silent idle cycles while requester 1 waits.
    fin_dly = 2;
    set_req(0, 1, 0, 1, 32'h40, 32'h0);
    set_req(1, 1, 0, 0, 32'h44, 32'h0);
    push_exp(0, 1'b0, 32'h40, 32'h0);
    wait_done();
    set_req(0, 0, 0, 0, 32'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("lock_hold_idle", busy, 0);
    end
    set_req(0, 1, 1, 0, 32'h48, 32'h55AA);
    push_exp(0, 1'b1, 32'h48, 32'h55AA);
    wait_done();
    set_req(0, 0, 0, 0, 32'h0, 32'h0);
    push_exp(1, 1'b0, 32'h44, 32'h0);
    wait_done();
    set_req(1, 0, 0, 0, 32'h0, 32'h0);

    // Lock timeout: the owner stays silent, and requester 1 is granted on the 4th idle cycle.
    set_req(0, 1, 0, 1, 32'h50, 32'h0);
    push_exp(0, 1'b0, 32'h50, 32'h0);
    wait_done();
    set_req(0, 0, 0, 0, 32'h0, 32'h0);
    set_req(1, 1, 0, 0, 32'h54, 32'h0);
    push_exp(1, 1'b0, 32'h54, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("lockto_idle_busy", busy, 0);
      check("lockto_idle_exec", m_exec, 0);
    end
    @(negedge clk);
    check("lockto_exec", m_exec, 1);
    check("lockto_exec_addr", m_addr, 32'h54);
    wait_done();
    set_req(1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    // Reset in WAIT: outputs return to reset values, and the late m_fin must be ignored.
    fin_dly = 6;
    set_req(1, 1, 0, 0, 32'h60, 32'h0);
    push_exp(1, 1'b0, 32'h60, 32'h0);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!m_exec && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("rst_exec_seen", m_exec, 1);
    end
    @(negedge clk);
    check("rst_in_wait_busy", busy, 1);
    reset     = 1'b1;
    drv_abort = 1'b1;
    sb_q.delete();
    set_req(1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check_reset_vals("rst_wait");
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("stale_fin_no_done", rsp_done, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
